ip_tx_pkt_arbiter: RTL and testbench

- Shares one IP header/data output channel between NUM_SRCS packet producers. The shared channel feeds the IP transmit path: an ip_pkt_hdr plus timestamp on the header channel, then MAC-width data beats with padbytes and last.
- Round-robin grant per packet. A grant is held from header acceptance through the data beat carrying last, so header and data of different sources never interleave.
- Sits between the per-flow header assemblers and the single downstream IP/MAC transmit consumer.

---
 rtl/ip_tx_pkt_arbiter.sv | 107 ++++++++++
 tb/tb_ip_tx_pkt_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ip_tx_pkt_arbiter.sv
// ip_tx_pkt_arbiter: per-packet round-robin share of one IP header/data channel among NUM_SRCS producers.
// The grant is held from the header handshake through the data beat carrying last.
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

module ip_tx_pkt_arbiter #(
    parameter int NUM_SRCS   = 2,
    parameter int SRC_W      = $clog2(NUM_SRCS),
    parameter int DATA_W     = `MAC_INTERFACE_W,
    parameter int PADBYTES_W = `MAC_PADBYTES_W,
    parameter int IP_HDR_W   = 160,
    parameter int TS_W       = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRCS-1:0]            src_arb_hdr_val,
    input  logic [NUM_SRCS*IP_HDR_W-1:0]   src_arb_ip_hdr,
    input  logic [NUM_SRCS*TS_W-1:0]       src_arb_timestamp,
    output logic [NUM_SRCS-1:0]            arb_src_hdr_rdy,
    input  logic [NUM_SRCS-1:0]            src_arb_data_val,
    input  logic [NUM_SRCS*DATA_W-1:0]     src_arb_data,
    input  logic [NUM_SRCS*PADBYTES_W-1:0] src_arb_data_padbytes,
    input  logic [NUM_SRCS-1:0]            src_arb_data_last,
    output logic [NUM_SRCS-1:0]            arb_src_data_rdy,
    output logic                           arb_dst_hdr_val,
    output logic [IP_HDR_W-1:0]            arb_dst_ip_hdr,
    output logic [TS_W-1:0]                arb_dst_timestamp,
    input  logic                           dst_arb_hdr_rdy,
    output logic                           arb_dst_data_val,
    output logic [DATA_W-1:0]              arb_dst_data,
    output logic [PADBYTES_W-1:0]          arb_dst_data_padbytes,
    output logic                           arb_dst_data_last,
    input  logic                           dst_arb_data_rdy,
    output logic                           arb_busy,
    output logic [SRC_W-1:0]               arb_grant_idx
);
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t           state, state_nxt;
    logic [SRC_W-1:0] grant_idx, last_grant, pick, cand;
    logic             found, hdr_fire, data_fire;

    // first requester strictly after last_grant, wrapping
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_SRCS; k++) begin
            cand = SRC_W'((int'(last_grant) + k) % NUM_SRCS);
            if (!found && src_arb_hdr_val[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign hdr_fire  = (state == HDR) && src_arb_hdr_val[grant_idx] && dst_arb_hdr_rdy;
    assign data_fire = (state == DATA) && src_arb_data_val[grant_idx] && dst_arb_data_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= SRC_W'(NUM_SRCS - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && found)
                grant_idx <= pick;
            if (data_fire && src_arb_data_last[grant_idx])
                last_grant <= grant_idx;
        end
    end

    always_comb begin
        state_nxt        = state;
        arb_dst_hdr_val  = 1'b0;
        arb_dst_data_val = 1'b0;
        arb_src_hdr_rdy  = '0;
        arb_src_data_rdy = '0;
        case (state)
            IDLE: state_nxt = found ? HDR : IDLE;
            HDR: begin
                arb_dst_hdr_val            = src_arb_hdr_val[grant_idx];
                arb_src_hdr_rdy[grant_idx] = dst_arb_hdr_rdy;
                state_nxt                  = hdr_fire ? DATA : HDR;
            end
            DATA: begin
                arb_dst_data_val            = src_arb_data_val[grant_idx];
                arb_src_data_rdy[grant_idx] = dst_arb_data_rdy;
                state_nxt = (data_fire && src_arb_data_last[grant_idx]) ? IDLE : DATA;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign arb_dst_ip_hdr        = src_arb_ip_hdr[grant_idx*IP_HDR_W +: IP_HDR_W];
    assign arb_dst_timestamp     = src_arb_timestamp[grant_idx*TS_W +: TS_W];
    assign arb_dst_data          = src_arb_data[grant_idx*DATA_W +: DATA_W];
    assign arb_dst_data_padbytes = src_arb_data_padbytes[grant_idx*PADBYTES_W +: PADBYTES_W];
    assign arb_dst_data_last     = src_arb_data_last[grant_idx];
    assign arb_busy              = (state != IDLE);
    assign arb_grant_idx         = grant_idx;
endmodule

// File: tb/tb_ip_tx_pkt_arbiter.sv
// tb_ip_tx_pkt_arbiter: directed per-cycle vectors for the 2-source arbiter plus reset and 3-source sequences.
module tb_ip_tx_pkt_arbiter;
    localparam int IHW = 16;
    localparam int TW  = 8;
    localparam int DW  = 16;
    localparam int PW  = 4;

    typedef struct packed {
        logic [1:0] hv, dv, dl;
        logic       hr, dr;
        logic       ehv;
        logic [1:0] ehr;
        logic       edv;
        logic [1:0] edr;
        logic       eb, eg;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      hv, dv, dl, hrdy_o, drdy_o;
    logic            hr, dr, hval_o, dval_o, last_o, busy_o, gidx_o;
    logic [2*IHW-1:0] hdr_i;
    logic [2*TW-1:0]  ts_i;
    logic [2*DW-1:0]  data_i;
    logic [2*PW-1:0]  pad_i;
    logic [IHW-1:0]   hdr_o;
    logic [TW-1:0]    ts_o;
    logic [DW-1:0]    data_o;
    logic [PW-1:0]    pad_o;

    logic [IHW-1:0] hdr_c  [2];
    logic [TW-1:0]  ts_c   [2];
    logic [DW-1:0]  data_c [2];
    logic [PW-1:0]  pad_c  [2];

    logic [2:0]       hv3, dv3, dl3, hrdy3_o, drdy3_o;
    logic             hr3, dr3, hval3_o, dval3_o, last3_o, busy3_o;
    logic [1:0]       gidx3_o;
    logic [3*IHW-1:0] hdr3_i = '0;
    logic [3*TW-1:0]  ts3_i  = '0;
    logic [3*DW-1:0]  data3_i = '0;
    logic [3*PW-1:0]  pad3_i = '0;
    logic [IHW-1:0]   hdr3_o;
    logic [TW-1:0]    ts3_o;
    logic [DW-1:0]    data3_o;
    logic [PW-1:0]    pad3_o;

    int checks = 0, errors = 0;
    logic [15:0] tbl [32];

    ip_tx_pkt_arbiter #(.NUM_SRCS(2), .DATA_W(DW), .PADBYTES_W(PW), .IP_HDR_W(IHW), .TS_W(TW)) u2 (
        .clk(clk), .rst(rst),
        .src_arb_hdr_val(hv), .src_arb_ip_hdr(hdr_i), .src_arb_timestamp(ts_i), .arb_src_hdr_rdy(hrdy_o),
        .src_arb_data_val(dv), .src_arb_data(data_i), .src_arb_data_padbytes(pad_i),
        .src_arb_data_last(dl), .arb_src_data_rdy(drdy_o),
        .arb_dst_hdr_val(hval_o), .arb_dst_ip_hdr(hdr_o), .arb_dst_timestamp(ts_o), .dst_arb_hdr_rdy(hr),
        .arb_dst_data_val(dval_o), .arb_dst_data(data_o), .arb_dst_data_padbytes(pad_o),
        .arb_dst_data_last(last_o), .dst_arb_data_rdy(dr),
        .arb_busy(busy_o), .arb_grant_idx(gidx_o)
    );

    ip_tx_pkt_arbiter #(.NUM_SRCS(3), .DATA_W(DW), .PADBYTES_W(PW), .IP_HDR_W(IHW), .TS_W(TW)) u3 (
        .clk(clk), .rst(rst),
        .src_arb_hdr_val(hv3), .src_arb_ip_hdr(hdr3_i), .src_arb_timestamp(ts3_i), .arb_src_hdr_rdy(hrdy3_o),
        .src_arb_data_val(dv3), .src_arb_data(data3_i), .src_arb_data_padbytes(pad3_i),
        .src_arb_data_last(dl3), .arb_src_data_rdy(drdy3_o),
        .arb_dst_hdr_val(hval3_o), .arb_dst_ip_hdr(hdr3_o), .arb_dst_timestamp(ts3_o), .dst_arb_hdr_rdy(hr3),
        .arb_dst_data_val(dval3_o), .arb_dst_data(data3_o), .arb_dst_data_padbytes(pad3_o),
        .arb_dst_data_last(last3_o), .dst_arb_data_rdy(dr3),
        .arb_busy(busy3_o), .arb_grant_idx(gidx3_o)
    );

    task automatic check(input vec_t v, input string nm);
        logic [7:0]  exp_b, act_b;
        logic [IHW+TW+DW+PW:0] exp_m, act_m;
        exp_b = {v.ehv, v.ehr, v.edv, v.edr, v.eb, v.eg};
        act_b = {hval_o, hrdy_o, dval_o, drdy_o, busy_o, gidx_o};
        checks++;
        if (act_b !== exp_b) begin
            errors++;
            $display("FAIL %s ctl {hval,hrdy,dval,drdy,busy,gidx} got %b want %b", nm, act_b, exp_b);
        end
        exp_m = {hdr_c[v.eg], ts_c[v.eg], data_c[v.eg], pad_c[v.eg], v.dl[v.eg]};
        act_m = {hdr_o, ts_o, data_o, pad_o, last_o};
        checks++;
        if (act_m !== exp_m) begin
            errors++;
            $display("FAIL %s mux got %h want %h", nm, act_m, exp_m);
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        {hv, dv, dl, hr, dr} = {v.hv, v.dv, v.dl, v.hr, v.dr};
        #1 check(v, nm);
    endtask

    task automatic step3(input logic [2:0] h, d, l, input logic r_h, r_d, input logic [10:0] exp, input string nm);
        logic [10:0] act;
        @(negedge clk);
        {hv3, dv3, dl3, hr3, dr3} = {h, d, l, r_h, r_d};
        #1 act = {hval3_o, hrdy3_o, dval3_o, drdy3_o, busy3_o, gidx3_o};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ctl3 {hval,hrdy,dval,drdy,busy,gidx} got %b want %b", nm, act, exp);
        end
    endtask

    initial begin
        hdr_c  = '{16'hA0A0, 16'hB1B1};
        ts_c   = '{8'h50, 8'h51};
        data_c = '{16'hD0D0, 16'hD1D1};
        pad_c  = '{4'h2, 4'h3};
        hdr_i  = {hdr_c[1], hdr_c[0]};
        ts_i   = {ts_c[1], ts_c[0]};
        data_i = {data_c[1], data_c[0]};
        pad_i  = {pad_c[1], pad_c[0]};
        {hv, dv, dl, hr, dr} = '0;
        {hv3, dv3, dl3, hr3, dr3} = '0;
        // hv dv dl hr dr | ehv ehr edv edr eb eg
        tbl = '{
            16'b01_00_00_1_1_0_00_0_00_0_0, 16'b01_00_00_1_1_1_01_0_00_1_0,
            16'b00_11_00_1_1_0_00_1_01_1_0, 16'b00_11_00_1_1_0_00_1_01_1_0,
            16'b00_11_01_1_1_0_00_1_01_1_0, 16'b00_00_00_1_1_0_00_0_00_0_0,
            16'b11_00_00_1_1_0_00_0_00_0_0, 16'b11_00_00_1_1_1_10_0_00_1_1,
            16'b11_11_11_1_1_0_00_1_10_1_1, 16'b11_00_00_1_1_0_00_0_00_0_1,
            16'b11_00_00_1_1_1_01_0_00_1_0, 16'b11_11_11_1_1_0_00_1_01_1_0,
            16'b11_00_00_1_1_0_00_0_00_0_0, 16'b11_00_00_1_1_1_10_0_00_1_1,
            16'b00_11_11_1_1_0_00_1_10_1_1, 16'b01_00_00_0_1_0_00_0_00_0_1,
            16'b01_01_00_0_1_1_00_0_00_1_0, 16'b01_01_00_0_1_1_00_0_00_1_0,
            16'b00_01_00_1_1_0_01_0_00_1_0, 16'b01_01_00_0_1_1_00_0_00_1_0,
            16'b01_01_00_0_1_1_00_0_00_1_0, 16'b01_01_00_1_1_1_01_0_00_1_0,
            16'b00_01_01_1_1_0_00_1_01_1_0, 16'b10_00_00_1_1_0_00_0_00_0_0,
            16'b10_00_00_1_1_1_10_0_00_1_1, 16'b01_10_00_1_1_0_00_1_10_1_1,
            16'b01_10_10_1_0_0_00_1_00_1_1, 16'b01_10_10_1_1_0_00_1_10_1_1,
            16'b01_00_00_1_1_0_00_0_00_0_1, 16'b01_00_00_1_1_1_01_0_00_1_0,
            16'b00_01_01_1_1_0_00_1_01_1_0, 16'b00_00_00_1_1_0_00_0_00_0_0
        };
        repeat (2) @(negedge clk);
        #1 check(vec_t'(16'h0), "reset");
        step3(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 11'b0_000_0_000_0_00, "reset3");
        rst = 1'b1;
        for (int i = 0; i < 32; i++)
            step(vec_t'(tbl[i]), $sformatf("v%0d", i));

        // reset asserted on beat 2 of a src1 packet, then src0 must win first
        step(vec_t'(16'b10_00_00_1_1_0_00_0_00_0_0), "r0");
        step(vec_t'(16'b10_00_00_1_1_1_10_0_00_1_1), "r1");
        step(vec_t'(16'b00_10_00_1_1_0_00_1_10_1_1), "r2");
        step(vec_t'(16'b00_10_00_1_1_0_00_1_10_1_1), "r3");
        #1 rst = 1'b0;
        #1 check(vec_t'(16'b00_10_00_1_1_0_00_0_00_0_0), "rst_async");
        @(negedge clk);
        #1 check(vec_t'(16'b00_10_00_1_1_0_00_0_00_0_0), "rst_held");
        {hv, dv, dl} = '0;
        rst = 1'b1;
        step(vec_t'(16'b11_00_00_1_1_0_00_0_00_0_0), "r4");
        step(vec_t'(16'b11_00_00_1_1_1_01_0_00_1_0), "r5");
        step(vec_t'(16'b00_01_01_1_1_0_00_1_01_1_0), "r6");

        // three sources, 0 and 2 requesting; source 1 offers data but must never see rdy
        step3(3'b101, 3'b000, 3'b000, 1'b1, 1'b1, 11'b0_000_0_000_0_00, "t0");
        step3(3'b101, 3'b000, 3'b000, 1'b1, 1'b1, 11'b1_001_0_000_1_00, "t1");
        step3(3'b000, 3'b111, 3'b111, 1'b1, 1'b1, 11'b0_000_1_001_1_00, "t2");
        step3(3'b101, 3'b010, 3'b000, 1'b1, 1'b1, 11'b0_000_0_000_0_00, "t3");
        step3(3'b101, 3'b010, 3'b000, 1'b1, 1'b1, 11'b1_100_0_000_1_10, "t4");
        step3(3'b000, 3'b111, 3'b111, 1'b1, 1'b1, 11'b0_000_1_100_1_10, "t5");
        step3(3'b101, 3'b010, 3'b000, 1'b1, 1'b1, 11'b0_000_0_000_0_10, "t6");
        step3(3'b101, 3'b010, 3'b000, 1'b1, 1'b1, 11'b1_001_0_000_1_00, "t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
